// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
// Holds the FSM state enum, default sizing and beat-counter width.
package fifo_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_DW    = 4;
  localparam int DEF_BURST = 2;

  // Wide enough for beat counts up to BURST-1 with BURST <= 15.
  localparam int BCW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO side bundle of the write arbiter.
// master: requesters + FIFO (drive req, req_data, full).
// slave : arbiter (drives gnt, wr, w_data, owner).
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW
);

  localparam int OW = idx_w(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               full;
  logic               wr;
  logic [DW-1:0]      w_data;
  logic [OW-1:0]      owner;

  modport master (
    output req,
    output req_data,
    output full,
    input  gnt,
    input  wr,
    input  w_data,
    input  owner
  );

  modport slave (
    input  req,
    input  req_data,
    input  full,
    output gnt,
    output wr,
    output w_data,
    output owner
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Wrap-around priority search: first set req bit at or after rr_ptr.
// Ports: req_i, rr_ptr_i in; valid_o (any req), idx_o (winner) out.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int OW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [OW-1:0]   rr_ptr_i,
  output logic            valid_o,
  output logic [OW-1:0]   idx_o
);

  // Scan farthest-first so the candidate closest to rr_ptr lands last.
  always_comb begin : p_search
    int j;
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = OW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter letting NREQ requesters share one sync FIFO write port.
// Ports: clk, reset (async active-low), bus (slave: req/req_data/full in, gnt/wr/w_data/owner out).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int DW    = DEF_DW,
  parameter int BURST = DEF_BURST
) (
  input  logic             clk,
  input  logic             reset,
  fifo_wr_arbiter_if.slave bus
);

  localparam int OW = idx_w(NREQ);

  state_e           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    rr_q, rr_d;
  logic [BCW-1:0]   beat_q, beat_d;

  logic             pick_vld;
  logic [OW-1:0]    pick_idx;
  logic [OW-1:0]    owner_nxt;
  logic [DW-1:0]    data_a [NREQ];
  logic             own_req;
  logic             at_last;
  logic             wr;
  logic [NREQ-1:0]  gnt;

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_q),
    .valid_o  (pick_vld),
    .idx_o    (pick_idx)
  );

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign data_a[i] = bus.req_data[i*DW +: DW];
  end

  assign own_req   = bus.req[owner_q];
  assign at_last   = (beat_q == BCW'(BURST - 1));
  assign owner_nxt = (owner_q == OW'(NREQ - 1)) ? '0
                                                : owner_q + OW'(1);

  // full gates the strobe directly, so a stalled owner never writes.
  assign wr = (state_q == OWN) & own_req & ~bus.full;

  always_comb begin
    gnt = '0;
    if (wr) gnt[owner_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = OWN;
          owner_d = pick_idx;
          beat_d  = '0;
        end
      end
      OWN: begin
        // Stall cycles (full=1, req held) match no item: hold everything.
        unique case (1'b1)
          !own_req, wr && at_last: begin
            state_d = IDLE;
            rr_d    = owner_nxt;
          end
          wr && !at_last: begin
            beat_d = beat_q + BCW'(1);
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.gnt    = gnt;
  assign bus.wr     = wr;
  assign bus.w_data = wr ? data_a[owner_q] : '0;
  assign bus.owner  = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter with a depth-4 FIFO model downstream.
// Scoreboard of expected writes plus a table of first-pick vectors.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int DW    = 4;
  localparam int BURST = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_wr_arbiter #(
    .NREQ  (NREQ),
    .DW    (DW),
    .BURST (BURST)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // depth-4 FIFO
  logic [DW-1:0] fmem [4];
  logic [1:0]    fwp, frp;
  logic [2:0]    fcnt;
  logic          rd;
  logic          fpush, fpop;

  assign bus.full = (fcnt == 3'd4);
  assign fpush    = bus.wr && !bus.full;
  assign fpop     = rd && (fcnt != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwp  <= '0;
      frp  <= '0;
      fcnt <= '0;
    end else begin
      if (fpush) begin
        fmem[fwp] <= bus.w_data;
        fwp       <= fwp + 2'd1;
      end
      if (fpop) frp <= frp + 2'd1;
      fcnt <= fcnt + {2'b0, fpush} - {2'b0, fpop};
    end
  end

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] req;
    logic       vld;
    logic [1:0] own;
  } vec_t;

  wr_t           exp_q [$];
  vec_t          tbl [9];
  logic [DW-1:0] dat [NREQ];
  logic          auto_inc;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic push(input int idx, input int d);
    wr_t e;
    e.idx  = idx;
    e.data = DW'(d);
    exp_q.push_back(e);
  endtask

  task automatic sb_done(input string nm);
    chk(nm, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = dat[i];
  endtask

  task automatic drive(input logic [3:0] r, input logic rdv);
    bus.req = r;
    rd      = rdv;
    #1;
  endtask

  task automatic tick();
    logic [NREQ-1:0] g;
    #1;
    g = bus.gnt;
    @(posedge clk);
    #1;
    if (auto_inc)
      for (int i = 0; i < NREQ; i++)
        if (g[i]) dat[i] = dat[i] + 1'b1;
    drive_data();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    rd       = 1'b0;
    auto_inc = 1'b0;
    for (int i = 0; i < NREQ; i++) dat[i] = DW'(i + 1);
    drive_data();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Every write is matched against the next expected entry.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n && bus.wr) begin
      chk("no_wr_when_full", 32'(bus.full), 32'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_write: gnt=%b w_data=%h expected none",
                 bus.gnt, bus.w_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_gnt", 32'(bus.gnt), 32'd1 << e.idx);
        chk("sb_data", 32'(bus.w_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] ew;

    tbl[0] = '{4'b0001, 1'b1, 2'd0};
    tbl[1] = '{4'b0010, 1'b1, 2'd1};
    tbl[2] = '{4'b0100, 1'b1, 2'd2};
    tbl[3] = '{4'b1000, 1'b1, 2'd3};
    tbl[4] = '{4'b1100, 1'b1, 2'd2};
    tbl[5] = '{4'b1010, 1'b1, 2'd1};
    tbl[6] = '{4'b0110, 1'b1, 2'd1};
    tbl[7] = '{4'b1111, 1'b1, 2'd0};
    tbl[8] = '{4'b0000, 1'b0, 2'd0};

    // reset state with all requests high
    bus.req  = 4'hf;
    rd       = 1'b0;
    auto_inc = 1'b0;
    for (int i = 0; i < NREQ; i++) dat[i] = DW'(i + 1);
    drive_data();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_wr", 32'(bus.wr), 32'd0);
    chk("rst_wdata", 32'(bus.w_data), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);

    // first pick after reset starts at requester 0
    for (int t = 0; t < 9; t++) begin
      do_reset();
      drive(tbl[t].req, 1'b1);
      chk("tbl_idle_gnt", 32'(bus.gnt), 32'd0);
      chk("tbl_idle_wr", 32'(bus.wr), 32'd0);
      if (tbl[t].vld) push(int'(tbl[t].own), int'(tbl[t].own) + 1);
      tick();
      drive(tbl[t].req, 1'b1);
      chk("tbl_owner", 32'(bus.owner), 32'(tbl[t].own));
      chk("tbl_gnt", 32'(bus.gnt),
          tbl[t].vld ? (32'd1 << tbl[t].own) : 32'd0);
      chk("tbl_wr", 32'(bus.wr), 32'(tbl[t].vld));
      tick();
      drive(4'b0000, 1'b1);
      tick();
      tick();
      sb_done("tbl_sb_empty");
    end

    // single requester: 2-beat burst, bubble, next tenure
    do_reset();
    auto_inc = 1'b1;
    push(0, 1);
    push(0, 2);
    push(0, 3);
    ew = 5'b10110;
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, 1'b1);
      chk("single_wr", 32'(bus.wr), 32'(ew[k]));
      chk("single_gnt", 32'(bus.gnt), ew[k] ? 32'd1 : 32'd0);
      tick();
    end
    drive(4'b0000, 1'b1);
    tick();
    tick();
    sb_done("single_sb_empty");

    // fairness with all requesters active
    do_reset();
    for (int o = 0; o < 5; o++) begin
      push(o % 4, (o % 4) + 1);
      push(o % 4, (o % 4) + 1);
    end
    for (int k = 0; k < 15; k++) begin
      drive(4'b1111, 1'b1);
      if (k % 3 == 0) begin
        chk("fair_bubble", 32'(bus.wr), 32'd0);
      end else begin
        chk("fair_wr", 32'(bus.wr), 32'd1);
        chk("fair_owner", 32'(bus.owner), 32'((k / 3) % 4));
      end
      tick();
    end
    drive(4'b0000, 1'b1);
    tick();
    tick();
    sb_done("fair_sb_empty");

    // wrap from owner 3 back to 0
    do_reset();
    push(3, 4);
    push(3, 4);
    push(0, 1);
    drive(4'b1000, 1'b1);
    tick();
    drive(4'b1001, 1'b1);
    chk("wrap_own3", 32'(bus.owner), 32'd3);
    tick();
    drive(4'b1001, 1'b1);
    tick();
    drive(4'b1001, 1'b1);
    chk("wrap_bubble", 32'(bus.wr), 32'd0);
    tick();
    drive(4'b1001, 1'b1);
    chk("wrap_owner", 32'(bus.owner), 32'd0);
    chk("wrap_gnt", 32'(bus.gnt), 32'd1);
    tick();
    drive(4'b0000, 1'b1);
    tick();
    tick();
    sb_done("wrap_sb_empty");

    // backpressure from a full FIFO
    do_reset();
    for (int k = 0; k < 4; k++) push(3, 4);
    push(1, 2);
    for (int k = 0; k < 6; k++) begin
      drive(4'b1000, 1'b0);
      tick();
    end
    drive(4'b0010, 1'b0);
    chk("bp_full", 32'(bus.full), 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(4'b0010, 1'b0);
      chk("bp_gnt", 32'(bus.gnt), 32'd0);
      chk("bp_wr", 32'(bus.wr), 32'd0);
      chk("bp_owner", 32'(bus.owner), 32'd1);
      tick();
    end
    drive(4'b0010, 1'b1);
    chk("bp_rd_cycle_wr", 32'(bus.wr), 32'd0);
    tick();
    drive(4'b0010, 1'b0);
    chk("bp_release_wr", 32'(bus.wr), 32'd1);
    chk("bp_release_gnt", 32'(bus.gnt), 32'b0010);
    chk("bp_release_data", 32'(bus.w_data), 32'd2);
    tick();
    drive(4'b0010, 1'b0);
    chk("bp_refull_wr", 32'(bus.wr), 32'd0);
    tick();
    drive(4'b0000, 1'b0);
    chk("bp_drop_wr", 32'(bus.wr), 32'd0);
    tick();
    drive(4'b0011, 1'b0);
    chk("bp_drop_idle_gnt", 32'(bus.gnt), 32'd0);
    tick();
    drive(4'b0011, 1'b0);
    chk("bp_next_owner", 32'(bus.owner), 32'd0);
    chk("bp_next_wr", 32'(bus.wr), 32'd0);
    tick();
    drive(4'b0000, 1'b0);
    tick();
    tick();
    sb_done("bp_sb_empty");

    // early drop by owner 2 moves the pointer to 3
    do_reset();
    push(2, 3);
    push(3, 4);
    drive(4'b0100, 1'b1);
    tick();
    drive(4'b0100, 1'b1);
    chk("drop_own2", 32'(bus.owner), 32'd2);
    chk("drop_first_wr", 32'(bus.wr), 32'd1);
    tick();
    drive(4'b1001, 1'b1);
    chk("drop_wr", 32'(bus.wr), 32'd0);
    chk("drop_gnt", 32'(bus.gnt), 32'd0);
    tick();
    drive(4'b1001, 1'b1);
    chk("drop_bubble", 32'(bus.wr), 32'd0);
    tick();
    drive(4'b1001, 1'b1);
    chk("drop_owner", 32'(bus.owner), 32'd3);
    chk("drop_next_gnt", 32'(bus.gnt), 32'b1000);
    tick();
    drive(4'b0000, 1'b1);
    tick();
    tick();
    sb_done("drop_sb_empty");

    // asynchronous reset in the middle of owner 1's burst
    do_reset();
    push(0, 1);
    push(0, 1);
    push(1, 2);
    for (int k = 0; k < 4; k++) begin
      drive(4'b0011, 1'b1);
      tick();
    end
    drive(4'b0011, 1'b1);
    chk("mid_owner", 32'(bus.owner), 32'd1);
    chk("mid_wr", 32'(bus.wr), 32'd1);
    tick();
    drive(4'b0011, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_rst_wr", 32'(bus.wr), 32'd0);
    chk("mid_rst_wdata", 32'(bus.w_data), 32'd0);
    chk("mid_rst_owner", 32'(bus.owner), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'b0011, 1'b1);
    chk("mid_rel_idle_gnt", 32'(bus.gnt), 32'd0);
    push(0, 1);
    tick();
    drive(4'b0011, 1'b1);
    chk("mid_rel_owner", 32'(bus.owner), 32'd0);
    chk("mid_rel_gnt", 32'(bus.gnt), 32'd1);
    tick();
    drive(4'b0000, 1'b1);
    tick();
    tick();
    sb_done("mid_sb_empty");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
